// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Drains words from a FIFO read port and sends each one as an asynchronous
// serial frame: one start bit (0), DATA_WIDTH data bits LSB first, and one
// stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
//
// Ports
//   clk           single clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   en            allows new words to be fetched from the FIFO
//   fifo_rd_en    one-cycle read request to the FIFO (registered)
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_val   FIFO read-valid, meaningful only the cycle after fifo_rd_en
//   tx            serial line, idle-high (registered)
//   busy          high while a frame is in START/DATA/STOP (registered)
//   frame_done    one-cycle pulse at the end of each stop bit (registered)
`timescale 1ns/1ps
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_val,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [BAUD_W-1:0]       baud_cnt_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   shift_d;
    logic                    tx_q;
    logic                    busy_q;
    logic                    frame_done_q;
    logic                    rd_en_q;

    // Shift register contents after the current data bit has been sent.
    assign shift_d = shift_q >> 1'b1;

    // Transmit FSM with registered outputs.
    //
    // The read request is registered, so it is decided on the clock edge that
    // enters an IDLE cycle (en sampled there) and is visible during that IDLE
    // cycle. The FIFO then answers in the following cycle, which is WAIT.
    // This gives the 2-cycle IDLE/WAIT polling rhythm and the 2-cycle
    // idle-high gap between back-to-back frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (rd_en_q) begin
                        // The request was visible this cycle; wait for the answer.
                        rd_en_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end else begin
                        rd_en_q <= en;
                    end
                end
                ST_WAIT: begin
                    // The only cycle in which the FIFO response is trusted;
                    // rd_val/rd_data are stale in every other cycle.
                    if (fifo_rd_val) begin
                        shift_q    <= fifo_rd_data;
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_START;
                    end else begin
                        rd_en_q <= en;
                        state_q <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            shift_q   <= shift_d;
                            tx_q      <= shift_d[0];
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q   <= '0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        rd_en_q      <= en;
                        state_q      <= ST_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    rd_en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
`timescale 1ns/1ps
module tb_fifo_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        bit         chk_gap;
        bit         abort;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          en;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_val;
    logic          tx;
    logic          busy;
    logic          frame_done;

    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   fd_cnt = 0;
    int   busy_cyc = 0;
    int   txlow_cnt = 0;
    int   mon_bit = -1;
    bit   stale_mode = 1'b0;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_val  (fifo_rd_val),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input bit gap, input bit abrt);
        exp_t e;
        e.data = d; e.chk_gap = gap; e.abort = abrt;
        fifo_q.push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input int target, input int bound, input string name);
        int n = 0;
        while (fd_cnt < target && n < bound) begin tick(1); n++; end
        chk(name, 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic wait_bit(input int b, input int bound, input string name);
        int n = 0;
        while (mon_bit != b && n < bound) begin tick(1); n++; end
        chk(name, 32'(mon_bit == b), 32'd1);
    endtask

    task automatic wait_rd(input int base, input int bound, input string name);
        int n = 0;
        while (rd_cnt <= base && n < bound) begin tick(1); n++; end
        chk(name, 32'(rd_cnt > base), 32'd1);
    endtask

    // FIFO model: a request seen in one cycle is answered in the next; the
    // answer is then held (stale) until the next request.
    initial begin : fifo_model
        logic req;
        fifo_rd_val  = 1'b0;
        fifo_rd_data = '0;
        forever begin
            @(negedge clk);
            req = fifo_rd_en;
            @(posedge clk);
            #1;
            if (stale_mode) begin
                fifo_rd_val  = 1'b1;
                fifo_rd_data = 8'h55;
            end else if (req) begin
                if (fifo_q.size() > 0) begin
                    fifo_rd_data = fifo_q.pop_front();
                    fifo_rd_val  = 1'b1;
                end else begin
                    fifo_rd_val = 1'b0;
                end
            end
        end
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) rd_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (busy === 1'b1) busy_cyc++;
        if (tx !== 1'b1) txlow_cnt++;
    end

    // Monitor: receives every frame on tx and checks it against the scoreboard.
    initial begin : monitor
        exp_t       it;
        int         idle_cnt;
        int         terr;
        bit         aborted;
        logic [7:0] rx;
        logic       lvl;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 || tx !== 1'b0) begin
                idle_cnt = (reset === 1'b1) ? 0 : idle_cnt + 1;
            end else begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    it.data = 8'h00; it.chk_gap = 1'b0; it.abort = 1'b0;
                end else begin
                    it = exp_q.pop_front();
                end
                if (it.chk_gap) chk("frame_gap", 32'(idle_cnt), 32'd2);
                terr = 0; aborted = 1'b0; rx = '0;
                for (int b = 0; b < DW + 2 && !aborted; b++) begin
                    mon_bit = b;
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (reset === 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0 && b >= 1 && b <= DW) rx[b-1] = tx;
                            lvl = (b == 0) ? 1'b0 : (b == DW + 1) ? 1'b1 : rx[b-1];
                            if (tx !== lvl || busy !== 1'b1) terr++;
                        end
                    end
                end
                mon_bit = -1;
                chk("frame_aborted", 32'(aborted), 32'(it.abort));
                if (!aborted) begin
                    chk("bit_timing", 32'(terr), 32'd0);
                    @(negedge clk);
                    chk("frame_end_tx_busy_done", {29'd0, tx, busy, frame_done}, 32'b101);
                    chk("frame_data", 32'(rx), 32'(it.data));
                    idle_cnt = 1;
                end else begin
                    idle_cnt = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int rd0, b0, fd0, t0;
        en    = 1'b0;
        reset = 1'b1;

        // Reset state
        tick(3);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        reset = 1'b0;
        tick(3);

        // Single byte 0xA5: one fetch, 40 busy cycles
        push_word(8'hA5, 1'b0, 1'b0);
        rd0 = rd_cnt; b0 = busy_cyc;
        en = 1'b1;
        wait_rd(rd0, 10, "single_fetch_timeout");
        en = 1'b0;
        wait_fd(1, 100, "single_frame_timeout");
        tick(10);
        chk("single_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        chk("single_busy_cycles", 32'(busy_cyc - b0), 32'd40);

        // Empty FIFO: polling every 2 cycles
        rd0 = rd_cnt; b0 = busy_cyc; fd0 = fd_cnt; t0 = txlow_cnt;
        en = 1'b1;
        tick(20);
        chk("empty_rd_pulses", 32'(rd_cnt - rd0), 32'd10);
        chk("empty_busy", 32'(busy_cyc - b0), 32'd0);
        chk("empty_frame_done", 32'(fd_cnt - fd0), 32'd0);
        chk("empty_tx_low", 32'(txlow_cnt - t0), 32'd0);
        en = 1'b0;
        tick(4);

        // Burst of three words, back to back
        fd0 = fd_cnt;
        push_word(8'h00, 1'b0, 1'b0);
        push_word(8'hFF, 1'b1, 1'b0);
        push_word(8'h3C, 1'b1, 1'b0);
        en = 1'b1;
        wait_fd(fd0 + 3, 600, "burst_timeout");
        rd0 = rd_cnt;
        tick(10);
        chk("burst_poll_resumes", 32'(rd_cnt - rd0), 32'd5);
        en = 1'b0;
        tick(4);

        // en dropped during data bit 3 of 0x81
        fd0 = fd_cnt;
        push_word(8'h81, 1'b0, 1'b0);
        en = 1'b1;
        wait_bit(4, 100, "endrop_bit3_timeout");
        en = 1'b0;
        wait_fd(fd0 + 1, 100, "endrop_frame_timeout");
        rd0 = rd_cnt; t0 = txlow_cnt;
        tick(20);
        chk("endrop_no_fetch", 32'(rd_cnt - rd0), 32'd0);
        chk("endrop_tx_idle", 32'(txlow_cnt - t0), 32'd0);

        // Reset during data bit 5
        push_word(8'h5A, 1'b0, 1'b1);
        en = 1'b1;
        wait_bit(6, 100, "reset_bit5_timeout");
        en = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        rd0 = rd_cnt;
        en = 1'b1;
        wait_rd(rd0, 10, "midrst_fresh_fetch");
        en = 1'b0;
        tick(6);

        // Stale valid held high with en=0: nothing starts
        stale_mode = 1'b1;
        rd0 = rd_cnt; b0 = busy_cyc; t0 = txlow_cnt;
        tick(40);
        chk("stale_no_fetch", 32'(rd_cnt - rd0), 32'd0);
        chk("stale_no_busy", 32'(busy_cyc - b0), 32'd0);
        chk("stale_tx_idle", 32'(txlow_cnt - t0), 32'd0);

        // Final bookkeeping
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("total_frame_done", 32'(fd_cnt), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
